// File: rtl/spi_master.sv
// Mode-0 SPI master: CPOL=0, CPHA=0, MSB first, 8-bit frames, SCK divided from SYSCLK.
// Supports single transfers and CS-held bursts, with an enforced CS-high gap between frames.
module spi_master #(
   parameter int HALF_PERIOD = 4,
   parameter int CS_GAP      = 4
) (
   input  logic       SYSCLK,
   input  logic       RST,
   input  logic [7:0] DIN,
   input  logic       START,
   input  logic       KEEP_CS,
   input  logic       RELEASE,
   output logic       READY,
   output logic       BUSY,
   output logic [7:0] DOUT,
   output logic       DONE,
   output logic       SCK,
   output logic       MOSI,
   input  logic       MISO,
   output logic       CS
);

   localparam logic [7:0] HP_LAST  = 8'(HALF_PERIOD - 1);
   localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

   typedef enum logic [2:0] {
      IDLE, SETUP, HIGH, LOW, BURST, GAP
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] div_cnt;
   logic [2:0] bit_cnt;
   logic       last_bit;
   logic       keep_cs;
   logic [7:0] tx, rx;
   logic       accept, hi_end, frame_end, counting;

   always_ff @(posedge SYSCLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      hi_end    = 1'b0;
      frame_end = 1'b0;
      counting  = 1'b0;
      case (state)
         IDLE: begin
            if (START) begin
               accept    = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            counting = 1'b1;
            if (div_cnt == HP_LAST) state_nxt = HIGH;
         end
         HIGH: begin
            counting = 1'b1;
            if (div_cnt == HP_LAST) begin
               hi_end    = 1'b1;
               state_nxt = LOW;
            end
         end
         LOW: begin
            counting = 1'b1;
            if (div_cnt == HP_LAST) begin
               if (last_bit) begin
                  frame_end = 1'b1;
                  state_nxt = keep_cs ? BURST : GAP;
               end else begin
                  state_nxt = HIGH;
               end
            end
         end
         BURST: begin
            // START takes precedence over RELEASE when both arrive together
            if (START) begin
               accept    = 1'b1;
               state_nxt = SETUP;
            end else if (RELEASE) begin
               state_nxt = GAP;
            end
         end
         GAP: begin
            counting = 1'b1;
            if (div_cnt == GAP_LAST) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pin outputs are decoded from the next state so every output is a plain register
   always_ff @(posedge SYSCLK) begin
      if (RST) begin
         div_cnt  <= 8'd0;
         bit_cnt  <= 3'd0;
         last_bit <= 1'b0;
         keep_cs  <= 1'b0;
         READY    <= 1'b1;
         BUSY     <= 1'b0;
         CS       <= 1'b1;
         SCK      <= 1'b0;
         MOSI     <= 1'b0;
         DOUT     <= 8'd0;
         DONE     <= 1'b0;
      end else begin
         div_cnt <= (state_nxt != state || !counting) ? 8'd0 : div_cnt + 8'd1;
         READY   <= (state_nxt == IDLE) || (state_nxt == BURST);
         BUSY    <= (state_nxt == SETUP) || (state_nxt == HIGH) || (state_nxt == LOW);
         CS      <= (state_nxt == IDLE) || (state_nxt == GAP);
         SCK     <= (state_nxt == HIGH);
         DONE    <= frame_end;
         if (accept) begin
            keep_cs  <= KEEP_CS;
            bit_cnt  <= 3'd0;
            last_bit <= 1'b0;
            MOSI     <= DIN[7];
         end
         if (hi_end) begin
            bit_cnt  <= bit_cnt + 3'd1;
            last_bit <= (bit_cnt == 3'd7);
            if (bit_cnt != 3'd7) MOSI <= tx[6];
         end
         if (frame_end) DOUT <= rx;
      end
   end

   always_ff @(posedge SYSCLK) begin
      if (accept)      tx <= DIN;
      else if (hi_end) tx <= {tx[6:0], 1'b0};
      if (hi_end)      rx <= {rx[6:0], MISO};
   end

endmodule
